// File: rtl/nes_poll_pkg.sv
// Shared definitions for the NES/SNES controller poll sequencer: register map,
// register bit positions, sequencer states and frame bit counts.
package nes_poll_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_PERIOD = 4'h1;
    localparam logic [3:0] ADDR_BTN0   = 4'h4;
    localparam logic [3:0] ADDR_BTN1   = 4'h5;
    localparam logic [3:0] ADDR_STATUS = 4'h6;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_SNES = 1;
    localparam int CTRL_TRIG = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_NEW     = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_PENDING = 3;

    localparam logic [4:0] NES_BITS  = 5'd8;
    localparam logic [4:0] SNES_BITS = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_FIRST,
        S_CLK_LO,
        S_CLK_HI,
        S_DONE
    } state_t;

endpackage

// File: rtl/nes_poll_timer.sv
// Auto-poll period timer: free-running unit prescaler plus an 8-bit unit counter
// that emits a one-cycle request every PERIOD units while enabled.
module nes_poll_timer #(
    parameter int UNIT_DIV = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] period,
    input  logic       period_wr,
    output logic       req
);
    import nes_poll_pkg::*;

    localparam int UW = (UNIT_DIV > 0) ? $clog2(UNIT_DIV + 1) : 1;

    logic [UW-1:0] pre;
    logic [7:0]    units;
    logic          tick;
    logic          expire;

    assign tick   = (pre == UW'(UNIT_DIV));
    assign expire = tick && (period != 8'd0) && (units == period - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            units <= 8'd0;
            req   <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            // A PERIOD write restarts the interval from zero.
            if (period_wr) begin
                units <= 8'd0;
            end else if (expire) begin
                units <= 8'd0;
            end else if (tick && (period != 8'd0)) begin
                units <= units + 8'd1;
            end
            req <= expire && en && !period_wr;
        end
    end

endmodule

// File: rtl/tqvp_nes_poll_sequencer.sv
// TinyQV byte peripheral that autonomously polls a NES/SNES serial pad and
// publishes an atomic active-high button snapshot with new/overrun status.
module tqvp_nes_poll_sequencer #(
    parameter int HALF_DIV = 383,
    parameter int UNIT_DIV = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    import nes_poll_pkg::*;

    // Counter wide enough for the two-half-period latch pulse.
    localparam int HW = $clog2(2 * (HALF_DIV + 1));
    localparam logic [HW-1:0] HALF_END  = HW'(HALF_DIV);
    localparam logic [HW-1:0] LATCH_END = HW'(2 * HALF_DIV + 1);

    state_t        state, state_n;
    logic [HW-1:0] hcnt;
    logic [4:0]    bcnt;
    logic [4:0]    nbits;
    logic          snes_q;
    logic [15:0]   sreg;
    logic [15:0]   btn;
    logic          ctrl_en, ctrl_snes;
    logic [7:0]    period;
    logic          new_data, overrun, pending, busy;
    logic          timer_req;
    logic          wr_ctrl, wr_period, wr_status, trig;
    logic          start, sample, done, last_bit;

    assign wr_ctrl   = data_write && (address == ADDR_CTRL);
    assign wr_period = data_write && (address == ADDR_PERIOD);
    assign wr_status = data_write && (address == ADDR_STATUS);
    assign trig      = wr_ctrl && data_in[CTRL_TRIG];

    assign nbits    = snes_q ? SNES_BITS : NES_BITS;
    assign last_bit = ((bcnt + 5'd1) == nbits);
    assign start    = (state == S_IDLE) && pending;
    assign done     = (state == S_DONE);
    assign busy     = (state != S_IDLE);

    nes_poll_timer #(
        .UNIT_DIV (UNIT_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ctrl_en),
        .period    (period),
        .period_wr (wr_period),
        .req       (timer_req)
    );

    always_comb begin
        state_n   = state;
        pad_latch = 1'b0;
        pad_clk   = 1'b1;
        sample    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) state_n = S_LATCH;
            end
            S_LATCH: begin
                pad_latch = 1'b1;
                if (hcnt == LATCH_END) state_n = S_FIRST;
            end
            S_FIRST: begin
                if (hcnt == HALF_END) begin
                    sample  = 1'b1;
                    state_n = S_CLK_LO;
                end
            end
            S_CLK_LO: begin
                pad_clk = 1'b0;
                if (hcnt == HALF_END) state_n = S_CLK_HI;
            end
            S_CLK_HI: begin
                if (hcnt == HALF_END) begin
                    sample  = 1'b1;
                    state_n = last_bit ? S_DONE : S_CLK_LO;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            hcnt   <= '0;
            bcnt   <= 5'd0;
            snes_q <= 1'b0;
        end else begin
            state <= state_n;
            hcnt  <= (state_n != state) ? '0 : hcnt + 1'b1;
            // Frame width is frozen at latch so CTRL writes only affect the next frame.
            if (start) begin
                snes_q <= ctrl_snes;
                bcnt   <= 5'd0;
            end else if (sample) begin
                bcnt <= bcnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            sreg <= 16'h0000;
        end else if (sample) begin
            sreg[bcnt[3:0]] <= ~pad_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en   <= 1'b0;
            ctrl_snes <= 1'b0;
            period    <= 8'h00;
            btn       <= 16'h0000;
            new_data  <= 1'b0;
            overrun   <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= data_in[CTRL_EN];
                ctrl_snes <= data_in[CTRL_SNES];
            end
            if (wr_period) period <= data_in;

            // Requests merge into a single pending flag; a fresh request beats the clear.
            if (trig || timer_req) begin
                pending <= 1'b1;
            end else if (start) begin
                pending <= 1'b0;
            end

            if (done) btn <= snes_q ? sreg : {8'h00, sreg[7:0]};

            // Hardware set wins over a simultaneous write-1-to-clear.
            if (done) begin
                new_data <= 1'b1;
            end else if (wr_status && data_in[STAT_NEW]) begin
                new_data <= 1'b0;
            end
            if (done && new_data) begin
                overrun <= 1'b1;
            end else if (wr_status && data_in[STAT_OVERRUN]) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL:   data_out = {6'b0, ctrl_snes, ctrl_en};
            ADDR_PERIOD: data_out = period;
            ADDR_BTN0:   data_out = btn[7:0];
            ADDR_BTN1:   data_out = btn[15:8];
            ADDR_STATUS: data_out = {4'b0, pending, overrun, new_data, busy};
            default:     data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_nes_poll_sequencer.sv
// Scoreboard bench for the NES/SNES poll sequencer with a behavioural pad model.
module tb_tqvp_nes_poll_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    tqvp_nes_poll_sequencer #(
        .HALF_DIV (3),
        .UNIT_DIV (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: latch reloads, each rising clock shifts; line is active-low.
    logic [15:0] pat = 16'h0000;
    int          idx = 0;
    always @(posedge pad_latch) idx = 0;
    always @(posedge pad_clk) if (!pad_latch) idx = idx + 1;
    assign pad_data = (idx < 16) ? ~pat[idx[3:0]] : 1'b1;

    logic lat_prev = 1'b0;
    logic clk_prev = 1'b1;
    int   lat_cyc = 0;
    int   prev_lat_cyc = 0;
    int   pulses = 0;
    always @(negedge clk) begin
        if (pad_latch && !lat_prev) begin
            prev_lat_cyc = lat_cyc;
            lat_cyc      = cyc;
            pulses       = 0;
        end
        if (!pad_clk && clk_prev) pulses = pulses + 1;
        lat_prev = pad_latch;
        clk_prev = pad_clk;
    end

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  st;
        logic [7:0]  np;
        logic [15:0] len;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        address = a;
        #1;
        v = data_out;
    endtask

    task automatic push(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] st,
                        input logic [7:0] np, input logic [15:0] len);
        exp_t e;
        e.b0 = b0; e.b1 = b1; e.st = st; e.np = np; e.len = len;
        sb.push_back(e);
    endtask

    // Wait for a STATUS flag, then pop the expected frame and compare everything.
    task automatic wait_frame(input string tag, input int bitn, input int limit);
        logic [7:0] s, b0, b1;
        logic       found;
        int         np, ln;
        exp_t       e;
        found = 1'b0;
        s = 8'h00;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            rd(4'h6, s);
            found = s[bitn];
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            done_cyc = cyc;
            np = pulses;
            ln = done_cyc - lat_cyc;
            rd(4'h4, b0);
            rd(4'h5, b1);
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_btn0"}, 32'(b0), 32'(e.b0));
                chk({tag, "_btn1"}, 32'(b1), 32'(e.b1));
                chk({tag, "_status"}, 32'(s), 32'(e.st));
                chk({tag, "_pulses"}, 32'(np), 32'(e.np));
                chk({tag, "_len"}, 32'(ln), 32'(e.len));
            end
        end
    endtask

    task automatic check_regs_zero(input string tag);
        logic [3:0] regs [5];
        logic [7:0] v;
        regs = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6};
        for (int i = 0; i < 5; i++) begin
            rd(regs[i], v);
            chk($sformatf("%s_reg%0h", tag, regs[i]), 32'(v), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v, s;
        logic       found;
        int         l0;

        // Power-on reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_latch", 32'(pad_latch), 32'd0);
        chk("rst_clk", 32'(pad_clk), 32'd1);
        check_regs_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // NES software trigger, line pattern 0,1,1,1,1,1,1,0
        pat = 16'h0081;
        push(8'h81, 8'h00, 8'h02, 8'd7, 16'd69);
        wr(4'h0, 8'h04);
        #1;
        chk("nes_latch_t1", 32'(pad_latch), 32'd0);
        @(negedge clk);
        #1;
        chk("nes_latch_t2", 32'(pad_latch), 32'd1);
        wait_frame("nes", 1, 300);
        rd(4'h0, v);
        chk("nes_ctrl_rd", 32'(v), 32'h00);

        // SNES frame
        wr(4'h6, 8'h06);
        pat = 16'h5AC3;
        push(8'hC3, 8'h5A, 8'h02, 8'd15, 16'd133);
        wr(4'h0, 8'h06);
        rd(4'h0, v);
        chk("snes_ctrl_rd", 32'(v), 32'h02);
        wait_frame("snes", 1, 400);

        // W1C of new_data landing in the DONE cycle
        wr(4'h6, 8'h06);
        pat = 16'h00F0;
        wr(4'h0, 8'h04);
        repeat (68) @(negedge clk);
        wr(4'h6, 8'h02);
        rd(4'h6, v);
        chk("w1c_collide", 32'(v), 32'h02);
        rd(4'h4, v);
        chk("w1c_btn0", 32'(v), 32'hF0);
        wr(4'h6, 8'h02);
        rd(4'h6, v);
        chk("w1c_clear", 32'(v), 32'h00);

        // Auto-poll every 8 units of 16 cycles
        pat = 16'hFF3C;
        push(8'h3C, 8'h00, 8'h02, 8'd7, 16'd69);
        push(8'h3C, 8'h00, 8'h06, 8'd7, 16'd69);
        wr(4'h0, 8'h01);
        wr(4'h1, 8'h08);
        rd(4'h1, v);
        chk("auto_period_rd", 32'(v), 32'h08);
        wait_frame("auto1", 1, 400);
        wait_frame("auto2", 2, 400);
        chk("auto_interval", 32'(lat_cyc - prev_lat_cyc), 32'd128);
        wr(4'h0, 8'h00);
        wr(4'h6, 8'h06);
        rd(4'h6, v);
        chk("auto_flags_clr", 32'(v), 32'h00);

        // Period shorter than a frame
        pat = 16'h0096;
        push(8'h96, 8'h00, 8'h0A, 8'd7, 16'd69);
        push(8'h96, 8'h00, 8'h0E, 8'd7, 16'd69);
        wr(4'h1, 8'h01);
        wr(4'h0, 8'h01);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            rd(4'h6, s);
            found = ((s & 8'h09) == 8'h09);
        end
        chk("short_pend_busy", 32'(found), 32'd1);
        wait_frame("short1", 1, 300);
        l0 = lat_cyc;
        for (int i = 0; i < 10 && lat_cyc == l0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("short_gap", 32'(lat_cyc - done_cyc), 32'd1);
        wait_frame("short2", 2, 300);
        chk("short_interval", 32'(lat_cyc - prev_lat_cyc), 32'd70);
        wr(4'h0, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            rd(4'h6, s);
            found = ((s & 8'h09) == 8'h00);
        end
        chk("short_drain", 32'(found), 32'd1);
        wr(4'h6, 8'h06);

        // Asynchronous reset in the middle of a frame
        pat = 16'h00FF;
        wr(4'h0, 8'h04);
        repeat (14) @(negedge clk);
        #1;
        chk("mid_clk_low", 32'(pad_clk), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_latch", 32'(pad_latch), 32'd0);
        chk("mid_rst_clk", 32'(pad_clk), 32'd1);
        check_regs_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
